func_3luts: RTL and testbench
=============================

Name: func_3luts

Overview:
- Fixed-topology 5-input Boolean function F(A,B,C,D,E) built from three 3-input LUTs.
- LUT contents are runtime-programmable registers, loaded from parameter defaults on reset.
- Provides a combinational output F and a registered copy F_q.
- Used as a small glue-logic / truth-table element. The truth-table bench drives A..E and samples F combinationally with no clock edge.

Parameters:
- INIT_X, 8'h80, reset contents of LUT X (default X = A&B&C).
- INIT_Y, 8'h96, reset contents of LUT Y (default Y = C^D^E).
- INIT_F, 8'hFC, reset contents of output LUT (default F = X|Y).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  1  function input, MSB of LUT X index.
- B  input  1  function input.
- C  input  1  function input, shared by LUT X (LSB) and LUT Y (MSB).
- D  input  1  function input.
- E  input  1  function input, LSB of LUT Y index and LSB of output LUT index.
- cfg_we  input  1  LUT write enable.
- cfg_sel  input  2  LUT select: 0=X, 1=Y, 2=F, 3=reserved.
- cfg_data  input  8  new LUT contents.
- F  output  1  combinational function result.
- F_q  output  1  F registered on clk.

Behaviour:
- LUT semantics: out = INIT[index], where index = {in2,in1,in0} and in2 is the MSB.
- LUT X: index {A,B,C}.
- LUT Y: index {C,D,E}.
- LUT F: index {X,Y,E}, driving output F.
- F is purely combinational from A..E and the current LUT registers. Zero latency, no clock needed. Settles within the same delta/time step as any input change.
- Default function after reset: F = (A&B&C) | (C^D^E).
- Reset: on a rising clk edge with rst=1, LUT registers load INIT_X / INIT_Y / INIT_F, and F_q clears to 0.
- Config write: on a rising clk edge with rst=0 and cfg_we=1, the register selected by cfg_sel loads cfg_data. The new contents affect F from that edge onward.
- cfg_sel=3 with cfg_we=1: no register changes.
- Reset and cfg_we asserted in the same cycle: reset wins, write is discarded.
- F_q: on each rising edge with rst=0, F_q takes the value F had just before the edge. This gives one-cycle latency.
- No X propagation requirements beyond standard RTL; all registers have defined reset values.

Decomposition:
- Package func_3luts_pkg holds:
  - typedef lut3_init_t (logic [7:0]);
  - typedef cfg_sel_t, an enum {SEL_X=0, SEL_Y=1, SEL_F=2, SEL_RSVD=3};
  - constants DEF_INIT_X, DEF_INIT_Y, DEF_INIT_F.
- One sub-module, lut3: a pure combinational 3-input LUT with an 8-bit init input, instantiated three times.
- Config registers and F_q live in the top level.

Test Plan:
- Reset with all inputs 0 -> F=0, F_q=0, LUT registers = 80/96/FC.
- Combinational sweep of stim 0..31 (A=bit4 .. E=bit0), default LUTs, 1 time-unit settle, no clock. Required F = (A&B&C)|(C^D^E). Spot values:
  - 00000->0
  - 00001->1
  - 00011->0
  - 00100->1
  - 11100->1
  - 11111->1
  - 10010->1
  - 11000->0
- Write cfg_sel=2, cfg_data=8'h00, then sweep all 32 inputs -> F=0 everywhere. Then write 8'hFF -> F=1 everywhere.
- Write cfg_sel=0, cfg_data=8'h01 (X = ~A&~B&~C), then set all inputs to 0 -> X=1, Y=0, F=1. Before the write, the same inputs give F=0.
- Assert rst and cfg_we (sel=1, data=8'h00) in the same cycle -> LUT Y = 8'h96 afterwards, so input 00001 still gives F=1.
- Toggle input 00000 -> 00001 between edges -> F changes immediately; F_q goes 0 then 1 one clk later. cfg_sel=3 write leaves F unchanged.

Source files
------------

// File: rtl/func_3luts_pkg.sv
// rtl/func_3luts_pkg.sv - shared types and reset defaults for the three-LUT function block
//
// Contents:
//   lut3_init_t  - 8-bit truth table of one 3-input LUT
//   cfg_sel_t    - configuration target select
//   DEF_INIT_*   - default LUT contents giving F = (A&B&C) | (C^D^E)
package func_3luts_pkg;

  typedef logic [7:0] lut3_init_t;

  typedef enum logic [1:0] {
    SEL_X    = 2'd0,
    SEL_Y    = 2'd1,
    SEL_F    = 2'd2,
    SEL_RSVD = 2'd3
  } cfg_sel_t;

  // X = A&B&C      : only index 3'b111 is set
  localparam lut3_init_t DEF_INIT_X = 8'h80;
  // Y = C^D^E      : odd-parity indices 1,2,4,7
  localparam lut3_init_t DEF_INIT_Y = 8'h96;
  // F = X|Y        : index {X,Y,E}, set whenever X or Y is 1
  localparam lut3_init_t DEF_INIT_F = 8'hFC;

endpackage

// File: rtl/func_3luts_lut3.sv
// rtl/func_3luts_lut3.sv - purely combinational 3-input lookup table
//
// Ports:
//   init  in  8  truth table, bit i is the output for index i
//   in2   in  1  index MSB
//   in1   in  1  index middle bit
//   in0   in  1  index LSB
//   out   out 1  init[{in2,in1,in0}]
module lut3
  import func_3luts_pkg::*;
(
  input  lut3_init_t init,
  input  logic       in2,
  input  logic       in1,
  input  logic       in0,
  output logic       out
);

  logic [2:0] index;

  assign index = {in2, in1, in0};
  assign out   = init[index];

endmodule

// File: rtl/func_3luts.sv
// rtl/func_3luts.sv - 5-input Boolean function built from three programmable 3-input LUTs
//
// Ports:
//   clk       in  1  system clock, rising edge
//   rst       in  1  synchronous active-high reset
//   A..E      in  1  function inputs
//   cfg_we    in  1  LUT write enable
//   cfg_sel   in  2  LUT select: 0=X, 1=Y, 2=F, 3=reserved (ignored)
//   cfg_data  in  8  new LUT contents
//   F         out 1  combinational result LUT_F[{X,Y,E}]
//   F_q       out 1  F registered on clk
module func_3luts
  import func_3luts_pkg::*;
#(
  parameter lut3_init_t INIT_X = DEF_INIT_X,
  parameter lut3_init_t INIT_Y = DEF_INIT_Y,
  parameter lut3_init_t INIT_F = DEF_INIT_F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       E,
  input  logic       cfg_we,
  input  logic [1:0] cfg_sel,
  input  logic [7:0] cfg_data,
  output logic       F,
  output logic       F_q
);

  lut3_init_t lut_x;
  lut3_init_t lut_y;
  lut3_init_t lut_f;

  logic x_out;
  logic y_out;

  // Configuration registers; reset takes priority over a simultaneous write.
  always_ff @(posedge clk) begin
    if (rst) begin
      lut_x <= INIT_X;
      lut_y <= INIT_Y;
      lut_f <= INIT_F;
    end else if (cfg_we) begin
      case (cfg_sel_t'(cfg_sel))
        SEL_X:   lut_x <= cfg_data;
        SEL_Y:   lut_y <= cfg_data;
        SEL_F:   lut_f <= cfg_data;
        default: ;
      endcase
    end
  end

  lut3 u_lut_x (
    .init (lut_x),
    .in2  (A),
    .in1  (B),
    .in0  (C),
    .out  (x_out)
  );

  lut3 u_lut_y (
    .init (lut_y),
    .in2  (C),
    .in1  (D),
    .in0  (E),
    .out  (y_out)
  );

  // E feeds both LUT Y and the output LUT directly.
  lut3 u_lut_f (
    .init (lut_f),
    .in2  (x_out),
    .in1  (y_out),
    .in0  (E),
    .out  (F)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      F_q <= 1'b0;
    end else begin
      F_q <= F;
    end
  end

endmodule

// File: tb/tb_func_3luts.sv
// tb/tb_func_3luts.sv - directed self-checking bench for func_3luts
module tb_func_3luts;

  logic       clk;
  logic       rst;
  logic       A, B, C, D, E;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_data;
  logic       F;
  logic       F_q;

  int n_checks;
  int n_fail;

  func_3luts dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .E        (E),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .F        (F),
    .F_q      (F_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] s);
    {A, B, C, D, E} = s;
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [7:0] data);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_data = data;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  function automatic logic ref_default(input logic [4:0] s);
    logic a, b, c, d, e;
    {a, b, c, d, e} = s;
    return (a & b & c) | (c ^ d ^ e);
  endfunction

  logic [4:0] spot_in  [8];
  logic       spot_exp [8];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    cfg_we   = 1'b0;
    cfg_sel  = 2'd0;
    cfg_data = 8'h00;
    {A, B, C, D, E} = 5'b00000;

    spot_in[0] = 5'b00000; spot_exp[0] = 1'b0;
    spot_in[1] = 5'b00001; spot_exp[1] = 1'b1;
    spot_in[2] = 5'b00011; spot_exp[2] = 1'b0;
    spot_in[3] = 5'b00100; spot_exp[3] = 1'b1;
    spot_in[4] = 5'b11100; spot_exp[4] = 1'b1;
    spot_in[5] = 5'b11111; spot_exp[5] = 1'b1;
    spot_in[6] = 5'b10010; spot_exp[6] = 1'b1;
    spot_in[7] = 5'b11000; spot_exp[7] = 1'b0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_F",     {31'd0, F},   32'd0);
    check("reset_F_q",   {31'd0, F_q}, 32'd0);
    check("reset_lut_x", {24'd0, dut.lut_x}, 32'h80);
    check("reset_lut_y", {24'd0, dut.lut_y}, 32'h96);
    check("reset_lut_f", {24'd0, dut.lut_f}, 32'hFC);

    // Combinational sweep with default tables, no clock edge relied upon
    for (int i = 0; i < 32; i++) begin
      set_in(i[4:0]);
      check($sformatf("default_sweep_%0d", i), {31'd0, F}, {31'd0, ref_default(i[4:0])});
    end
    for (int i = 0; i < 8; i++) begin
      set_in(spot_in[i]);
      check($sformatf("spot_%05b", spot_in[i]), {31'd0, F}, {31'd0, spot_exp[i]});
    end

    // Output LUT forced to constant 0 then constant 1
    cfg_write(2'd2, 8'h00);
    for (int i = 0; i < 32; i++) begin
      set_in(i[4:0]);
      check($sformatf("f_zero_%0d", i), {31'd0, F}, 32'd0);
    end
    cfg_write(2'd2, 8'hFF);
    for (int i = 0; i < 32; i++) begin
      set_in(i[4:0]);
      check($sformatf("f_one_%0d", i), {31'd0, F}, 32'd1);
    end
    cfg_write(2'd2, 8'hFC);

    // LUT X rewritten to NOR3
    set_in(5'b00000);
    check("x_before_write", {31'd0, F}, 32'd0);
    cfg_write(2'd0, 8'h01);
    set_in(5'b00000);
    check("x_after_write", {31'd0, F}, 32'd1);
    check("x_reg", {24'd0, dut.lut_x}, 32'h01);
    cfg_write(2'd0, 8'h80);

    // Reset wins over a simultaneous write
    @(negedge clk);
    rst      = 1'b1;
    cfg_we   = 1'b1;
    cfg_sel  = 2'd1;
    cfg_data = 8'h00;
    @(negedge clk);
    rst    = 1'b0;
    cfg_we = 1'b0;
    #1;
    check("rst_vs_we_lut_y", {24'd0, dut.lut_y}, 32'h96);
    set_in(5'b00001);
    check("rst_vs_we_F", {31'd0, F}, 32'd1);

    // Immediate F, one-cycle F_q
    @(negedge clk);
    set_in(5'b00000);
    @(posedge clk);
    #1;
    check("fq_low", {31'd0, F_q}, 32'd0);
    @(negedge clk);
    set_in(5'b00001);
    check("f_immediate", {31'd0, F}, 32'd1);
    check("fq_still_low", {31'd0, F_q}, 32'd0);
    @(posedge clk);
    #1;
    check("fq_high", {31'd0, F_q}, 32'd1);

    // Reserved select leaves everything unchanged
    cfg_write(2'd3, 8'h00);
    #1;
    check("rsvd_F", {31'd0, F}, 32'd1);
    check("rsvd_lut_x", {24'd0, dut.lut_x}, 32'h80);
    check("rsvd_lut_y", {24'd0, dut.lut_y}, 32'h96);
    check("rsvd_lut_f", {24'd0, dut.lut_f}, 32'hFC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
